spi_motor_rx: RTL and testbench

- Parametrised successor to the MCU-to-FPGA SPI motor-command receiver.
- Runs entirely in the system clock domain: oversamples the SPI pins, shifts in NUM_CH channels of CH_W bits, and commits them atomically only on a correctly sized frame.
- Returns a status byte on sdo.
- Includes a command watchdog that zeroes the motor commands if the MCU stops sending.
- Sits between the MCU SPI pins and the motor PWM/drive blocks.

---
 rtl/spi_motor_rx.sv | 151 +++++++++++++++
 tb/tb_spi_motor_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_motor_rx.sv
// SPI motor-command receiver: oversampled SPI slave with atomic frame commit,
// status byte readback on sdo and a command watchdog.
module spi_motor_rx #(
    parameter int NUM_CH         = 2,
    parameter int CH_W           = 8,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sck,
    input  logic                     load,
    input  logic                     sdi,
    output logic                     sdo,
    output logic [NUM_CH*CH_W-1:0]   motor,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic                     timeout
);

    localparam int FRAME_W = NUM_CH * CH_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES);

    logic               r_sck_s1, r_sck_s2, r_sck_h;
    logic               r_load_s1, r_load_s2, r_load_h;
    logic               r_sdi_s1, r_sdi_s2;
    logic [1:0]         r_warm;
    logic [FRAME_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_bits;
    logic [7:0]         r_tx;
    logic               r_active;
    logic               r_end_ok, r_end_err;
    logic [5:0]         r_cnt;
    logic               r_last_err;
    logic [WD_W-1:0]    r_wd;
    logic [FRAME_W-1:0] r_motor;
    logic               r_fv, r_fe, r_timeout;

    logic               w_live;
    logic               w_sck_rise, w_sck_fall;
    logic               w_load_fall, w_load_rise;
    logic [WD_W-1:0]    w_wd_inc;
    logic               w_expire;

    // Edges are ignored until the history flops hold real pin samples, so
    // a load already low at reset release is not mistaken for a frame start.
    assign w_live      = (r_warm == 2'd3);
    assign w_sck_rise  = w_live & r_sck_s2 & ~r_sck_h & ~r_load_s2;
    assign w_sck_fall  = w_live & ~r_sck_s2 & r_sck_h & ~r_load_s2;
    assign w_load_fall = w_live & ~r_load_s2 & r_load_h;
    assign w_load_rise = w_live & r_load_s2 & ~r_load_h;

    assign w_wd_inc = (r_wd == WD_MAX) ? r_wd : r_wd + 1'b1;
    assign w_expire = (TIMEOUT_CYCLES != 0) && (w_wd_inc == WD_MAX);

    assign sdo         = ~r_load_s2 & r_tx[7];
    assign motor       = r_motor;
    assign frame_valid = r_fv;
    assign frame_err   = r_fe;
    assign timeout     = r_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_h   <= 1'b0;
            r_load_s1 <= 1'b1;
            r_load_s2 <= 1'b1;
            r_load_h  <= 1'b1;
            r_sdi_s1  <= 1'b0;
            r_sdi_s2  <= 1'b0;
            r_warm    <= 2'd0;
        end else begin
            r_sck_s1  <= sck;
            r_sck_s2  <= r_sck_s1;
            r_sck_h   <= r_sck_s2;
            r_load_s1 <= load;
            r_load_s2 <= r_load_s1;
            r_load_h  <= r_load_s2;
            r_sdi_s1  <= sdi;
            r_sdi_s2  <= r_sdi_s1;
            if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift   <= '0;
            r_bits    <= '0;
            r_tx      <= '0;
            r_active  <= 1'b0;
            r_end_ok  <= 1'b0;
            r_end_err <= 1'b0;
        end else begin
            r_end_ok  <= 1'b0;
            r_end_err <= 1'b0;
            if (w_load_fall) begin
                r_bits   <= '0;
                r_tx     <= {r_timeout, r_last_err, r_cnt};
                r_active <= 1'b1;
            end else begin
                if (w_sck_rise) begin
                    r_shift <= {r_shift[FRAME_W-2:0], r_sdi_s2};
                    if (r_bits != CNT_SAT) r_bits <= r_bits + 1'b1;
                end
                if (w_sck_fall) r_tx <= {r_tx[6:0], 1'b0};
                if (w_load_rise) begin
                    r_active  <= 1'b0;
                    r_end_ok  <= r_active & (r_bits == CNT_FULL);
                    r_end_err <= r_active ? (r_bits != CNT_FULL)
                                          : (r_bits != '0);
                end
            end
        end
    end

    // A commit in the expiry cycle wins: motor loads and the watchdog rearms.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_motor    <= '0;
            r_fv       <= 1'b0;
            r_fe       <= 1'b0;
            r_cnt      <= '0;
            r_last_err <= 1'b0;
            r_wd       <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_fv <= r_end_ok;
            r_fe <= r_end_err;
            if (r_end_ok) begin
                r_motor    <= r_shift;
                r_cnt      <= r_cnt + 6'd1;
                r_last_err <= 1'b0;
                r_wd       <= '0;
                r_timeout  <= 1'b0;
            end else begin
                if (r_end_err) r_last_err <= 1'b1;
                r_wd <= w_wd_inc;
                if (w_expire) begin
                    r_timeout <= 1'b1;
                    r_motor   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_motor_rx.sv
// Randomised bench for spi_motor_rx: three instances (2x8 no watchdog,
// 2x8 with 100-cycle watchdog, 4x12 no watchdog) against a frame-level model.
module tb_spi_motor_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sck = 3'b000;
    logic [2:0] load = 3'b111;
    logic [2:0] sdi = 3'b000;
    logic [2:0] sdo, fv, fe, to;
    logic [15:0] mot_a, mot_w;
    logic [47:0] mot_b;

    int total = 0;
    int bad = 0;
    int ncyc = 0;

    localparam int FW [3] = '{16, 16, 48};
    localparam int TO [3] = '{0, 100, 0};

    int          ev_cyc  [3] = '{-1, -1, -1};
    logic        ev_ok   [3] = '{1'b0, 1'b0, 1'b0};
    logic [63:0] ev_data [3] = '{64'd0, 64'd0, 64'd0};
    logic [63:0] m_motor [3] = '{64'd0, 64'd0, 64'd0};
    int          anchor  [3] = '{0, 0, 0};
    int          m_cnt   [3] = '{0, 0, 0};
    logic        m_lerr  [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) ncyc = ncyc + 1;

    spi_motor_rx #(.NUM_CH(2), .CH_W(8), .TIMEOUT_CYCLES(0)) u_a (
        .clk(clk), .reset_n(rst_n), .sck(sck[0]), .load(load[0]),
        .sdi(sdi[0]), .sdo(sdo[0]), .motor(mot_a), .frame_valid(fv[0]),
        .frame_err(fe[0]), .timeout(to[0]));

    spi_motor_rx #(.NUM_CH(2), .CH_W(8), .TIMEOUT_CYCLES(100)) u_w (
        .clk(clk), .reset_n(rst_n), .sck(sck[1]), .load(load[1]),
        .sdi(sdi[1]), .sdo(sdo[1]), .motor(mot_w), .frame_valid(fv[1]),
        .frame_err(fe[1]), .timeout(to[1]));

    spi_motor_rx #(.NUM_CH(4), .CH_W(12), .TIMEOUT_CYCLES(0)) u_b (
        .clk(clk), .reset_n(rst_n), .sck(sck[2]), .load(load[2]),
        .sdi(sdi[2]), .sdo(sdo[2]), .motor(mot_b), .frame_valid(fv[2]),
        .frame_err(fe[2]), .timeout(to[2]));

    function automatic logic [63:0] dut_motor(input int d);
        case (d)
            0:       return {48'd0, mot_a};
            1:       return {48'd0, mot_w};
            default: return {16'd0, mot_b};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: pulses land 4 edges after load rises at the pin; watchdog trips
    // TIMEOUT edges after the last commit (or reset release).
    always @(negedge clk) begin
        logic xfv, xfe, xto;
        for (int d = 0; d < 3; d++) begin
            xfv = 1'b0;
            xfe = 1'b0;
            xto = 1'b0;
            if (!rst_n) begin
                m_motor[d] = '0;
                anchor[d]  = ncyc + 1;
            end else begin
                if (ev_cyc[d] == ncyc) begin
                    xfv = ev_ok[d];
                    xfe = !ev_ok[d];
                    if (ev_ok[d]) begin
                        m_motor[d] = ev_data[d];
                        anchor[d]  = ncyc;
                    end
                end
                xto = (TO[d] > 0) && (ncyc - anchor[d] >= TO[d]);
                if (xto) m_motor[d] = '0;
            end
            chk($sformatf("motor%0d", d), dut_motor(d), m_motor[d]);
            chk($sformatf("valid%0d", d), {63'd0, fv[d]}, {63'd0, xfv});
            chk($sformatf("err%0d", d), {63'd0, fe[d]}, {63'd0, xfe});
            chk($sformatf("timeout%0d", d), {63'd0, to[d]}, {63'd0, xto});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input int d, input logic [63:0] data,
                              input int n, output logic [7:0] st);
        st = '0;
        for (int i = n - 1; i >= 0; i--) begin
            sdi[d] = data[i];
            tick(4);
            if (n - 1 - i < 8) st[7-(n-1-i)] = sdo[d];
            sck[d] = 1'b1;
            tick(4);
            sck[d] = 1'b0;
        end
    endtask

    task automatic end_frame(input int d, input logic [63:0] data,
                             input logic ok);
        load[d]    = 1'b1;
        ev_ok[d]   = ok;
        ev_data[d] = data;
        ev_cyc[d]  = ncyc + 4;
        if (ok) begin
            m_cnt[d]  = (m_cnt[d] + 1) % 64;
            m_lerr[d] = 1'b0;
        end else begin
            m_lerr[d] = 1'b1;
        end
        tick(8);
    endtask

    task automatic send(input int d, input logic [63:0] data, input int n,
                        output logic [7:0] st);
        logic [7:0] exp;
        logic [63:0] msk;
        exp = {1'b0, m_lerr[d], 6'(m_cnt[d])};
        load[d] = 1'b0;
        tick(8);
        shift_bits(d, data, n, st);
        tick(4);
        msk = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
        end_frame(d, data & msk, n == FW[d]);
        if (TO[d] == 0 && n >= 8) chk($sformatf("status%0d", d), {56'd0, st}, {56'd0, exp});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_motor", {48'd0, mot_a}, 64'd0);
        chk("rst_out", {60'd0, fv[0], fe[0], to[0], sdo[0]}, 64'd0);
        load = 3'b111;
        sck  = 3'b000;
        for (int d = 0; d < 3; d++) begin
            m_cnt[d]  = 0;
            m_lerr[d] = 1'b0;
        end
        tick(4);
        rst_n = 1'b1;
        tick(6);
    endtask

    initial begin
        logic [7:0]  st;
        logic [63:0] r;
        int          sel, n;
        tick(5);
        rst_n = 1'b1;
        tick(6);

        send(0, 64'h1111, 16, st);
        send(0, 64'h2222, 16, st);
        send(0, 64'hA53C, 16, st);
        chk("lit_a53c", {48'd0, mot_a}, 64'hA53C);
        send(0, 64'h7FFF, 15, st);
        chk("lit_st03", {56'd0, st}, 64'h03);
        send(0, 64'h1FFFF, 17, st);
        chk("lit_keep", {48'd0, mot_a}, 64'hA53C);
        send(0, 64'h0F0F, 16, st);
        chk("lit_st43", {56'd0, st}, 64'h43);

        // zero-length frame: load low for one clk, no sck
        load[0] = 1'b0;
        tick(1);
        end_frame(0, 64'd0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            sel = $urandom_range(0, 5);
            n = (sel < 3) ? 16 : (sel == 3) ? 15 : (sel == 4) ? 17
                                 : $urandom_range(1, 14);
            r = {32'd0, $urandom};
            send(0, r, n, st);
        end
        while (m_cnt[0] != 0) send(0, {48'd0, 16'($urandom)}, 16, st);
        send(0, 64'h5A5A, 16, st);
        chk("lit_wrap", {58'd0, st[5:0]}, 64'd0);

        // reset after 9 bits of a frame
        load[0] = 1'b0;
        tick(8);
        shift_bits(0, 64'h1FF, 9, st);
        do_reset();
        send(0, 64'h0102, 16, st);
        chk("lit_0102", {48'd0, mot_a}, 64'h0102);

        send(1, 64'hFFFF, 16, st);
        chk("lit_wd_ffff", {47'd0, to[1], mot_w}, 64'hFFFF);
        tick(100);
        chk("lit_wd_trip", {47'd0, to[1], mot_w}, 64'h10000);
        send(1, 64'h1234, 16, st);
        chk("lit_wd_1234", {47'd0, to[1], mot_w}, 64'h1234);

        for (int k = 0; k < 5; k++) begin
            sck[2] = 1'b1;
            tick(4);
            sck[2] = 1'b0;
            tick(4);
        end
        send(2, 64'h123456789ABC, 48, st);
        chk("lit_48b", {16'd0, mot_b}, 64'h123456789ABC);
        for (int k = 0; k < 4; k++) begin
            r = {$urandom, $urandom};
            send(2, r, (k == 2) ? 47 : 48, st);
        end

        tick(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
